// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkg
// Description : Shared types and helpers for the multi-direction traffic
//               light controller: phase encoding, direction limits and a
//               round-robin index helper. FLASH exists only when
//               TL_NIGHT_MODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package tl_pkg;

    localparam int TL_DIR_MAX = 8;
    localparam int TL_DIR_W   = 3;

    typedef enum logic [2:0] {
        GREEN     = 3'd0,
        BLINK_OFF = 3'd1,
        BLINK_ON  = 3'd2,
        YELLOW    = 3'd3,
        ALL_RED   = 3'd4
`ifdef TL_NIGHT_MODE_EN
        ,
        FLASH     = 3'd5
`endif
    } tl_phase_e;

    // (idx + step) mod n, used to walk the approaches in service order
    function automatic logic [TL_DIR_W-1:0] tl_rr_next(
        input logic [TL_DIR_W-1:0] idx,
        input int unsigned         step,
        input int unsigned         n
    );
        return TL_DIR_W'((32'(idx) + step) % n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tl_phase_timer
// Description : Loadable phase counter. Counts 1,2,3,... and flags done when
//               the count equals the current phase limit; load restarts at 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_phase_timer #(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] limit_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;

    // Counter restarts at 1 on reset or on every phase change
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CW'(1);
        end else if (load_i) begin
            cnt_q <= CW'(1);
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign done_o = (cnt_q == limit_i);

endmodule
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_ctrl
// Description : Round-robin intersection controller for NUM_DIR approaches.
//               Each approach runs GREEN, blink pairs, YELLOW and an all-red
//               clearance. Pending pass requests truncate green and pick the
//               next approach. Optional night flashing-yellow mode is built
//               when TL_NIGHT_MODE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int NUM_DIR   = 2,
    parameter int CW        = 12,
    parameter int G_CYC     = 1024,
    parameter int BLINK_CYC = 128,
    parameter int BLINK_NUM = 2,
    parameter int Y_CYC     = 512,
    parameter int AR_CYC    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DIR-1:0] pass_i,
`ifdef TL_NIGHT_MODE_EN
    input  logic               night_i,
`endif
    output logic [NUM_DIR-1:0] r_o,
    output logic [NUM_DIR-1:0] g_o,
    output logic [NUM_DIR-1:0] y_o
);

    localparam int              BW         = (BLINK_NUM > 1) ? $clog2(BLINK_NUM) : 1;
    localparam logic [BW-1:0]   LAST_BLINK = BW'(BLINK_NUM - 1);

    // Parameter sanity: durations must be representable and non-zero
    if (NUM_DIR < 1 || NUM_DIR > TL_DIR_MAX) begin : g_bad_num_dir
        $error("NUM_DIR out of range 1..8");
    end
    if (G_CYC < 1 || G_CYC >= 2**CW || BLINK_CYC < 1 || BLINK_CYC >= 2**CW ||
        Y_CYC < 1 || Y_CYC >= 2**CW || AR_CYC < 1 || AR_CYC >= 2**CW ||
        BLINK_NUM < 0) begin : g_bad_duration
        $error("phase duration outside 1..2^CW-1");
    end

    tl_phase_e             phase_q,     phase_d;
    logic [TL_DIR_W-1:0]   active_q,    active_d;
    logic [BW-1:0]         blink_idx_q, blink_idx_d;
    logic [NUM_DIR-1:0]    pending_q,   pending_d;
`ifdef TL_NIGHT_MODE_EN
    logic                  flash_on_q,  flash_on_d;
    logic                  from_flash_q, from_flash_d;
`endif

    logic                  w_load;
    logic                  w_done;
    logic [CW-1:0]         w_limit;
    logic [NUM_DIR-1:0]    w_act_oh;
    logic [NUM_DIR-1:0]    w_green_oh;
    logic [NUM_DIR-1:0]    w_pass_eff;
    logic [TL_DIR_W-1:0]   w_scan_dir;
    logic [TL_DIR_W-1:0]   w_green_dir;
    logic [TL_DIR_W-1:0]   w_idx;
    logic                  w_trunc;

    tl_phase_timer #(
        .CW      (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .limit_i (w_limit),
        .done_o  (w_done)
    );

    // Duration of the phase currently being timed
    always_comb begin
        w_limit = CW'(G_CYC);
        case (phase_q)
            GREEN:     w_limit = CW'(G_CYC);
            BLINK_OFF: w_limit = CW'(BLINK_CYC);
            BLINK_ON:  w_limit = CW'(BLINK_CYC);
            YELLOW:    w_limit = CW'(Y_CYC);
            ALL_RED:   w_limit = CW'(AR_CYC);
`ifdef TL_NIGHT_MODE_EN
            FLASH:     w_limit = CW'(BLINK_CYC);
`endif
            default:   w_limit = CW'(G_CYC);
        endcase
    end

    // Next approach: first pending one after active in ring order, else active+1
    always_comb begin
        w_scan_dir = tl_rr_next(active_q, 1, NUM_DIR);
        w_idx      = '0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            w_idx = tl_rr_next(active_q, $unsigned(k), NUM_DIR);
            for (int i = 0; i < NUM_DIR; i++) begin
                if (w_idx == TL_DIR_W'(i) && pending_q[i]) begin
                    w_scan_dir = w_idx;
                end
            end
        end
`ifdef TL_NIGHT_MODE_EN
        w_green_dir = from_flash_q ? '0 : w_scan_dir;
`else
        w_green_dir = w_scan_dir;
`endif
    end

    // One-hot views of the active and next-green approaches, plus request masking
    always_comb begin
        for (int i = 0; i < NUM_DIR; i++) begin
            w_act_oh[i]   = (active_q    == TL_DIR_W'(i));
            w_green_oh[i] = (w_green_dir == TL_DIR_W'(i));
        end
        w_pass_eff = pass_i & ~((phase_q == GREEN) ? w_act_oh : '0);
        w_trunc    = |(pending_q & ~w_act_oh);
    end

    // Phase sequencing: night overrides truncation, which overrides the timer
    always_comb begin
        phase_d      = phase_q;
        active_d     = active_q;
        blink_idx_d  = blink_idx_q;
        pending_d    = pending_q | w_pass_eff;
        w_load       = 1'b0;
`ifdef TL_NIGHT_MODE_EN
        flash_on_d   = flash_on_q;
        from_flash_d = from_flash_q;
        if (night_i) begin
            if (phase_q != FLASH) begin
                phase_d    = FLASH;
                flash_on_d = 1'b1;
                pending_d  = '0;
                w_load     = 1'b1;
            end else if (w_done) begin
                flash_on_d = ~flash_on_q;
                w_load     = 1'b1;
            end
        end else if (phase_q == FLASH) begin
            phase_d      = ALL_RED;
            from_flash_d = 1'b1;
            w_load       = 1'b1;
        end else
`endif
        begin
            case (phase_q)
                GREEN: begin
                    if (w_trunc) begin
                        phase_d = YELLOW;
                        w_load  = 1'b1;
                    end else if (w_done) begin
                        phase_d     = (BLINK_NUM == 0) ? YELLOW : BLINK_OFF;
                        blink_idx_d = '0;
                        w_load      = 1'b1;
                    end
                end
                BLINK_OFF: begin
                    if (w_done) begin
                        phase_d = BLINK_ON;
                        w_load  = 1'b1;
                    end
                end
                BLINK_ON: begin
                    if (w_done) begin
                        if (blink_idx_q == LAST_BLINK) begin
                            phase_d = YELLOW;
                        end else begin
                            phase_d     = BLINK_OFF;
                            blink_idx_d = blink_idx_q + 1'b1;
                        end
                        w_load = 1'b1;
                    end
                end
                YELLOW: begin
                    if (w_done) begin
                        phase_d = ALL_RED;
                        w_load  = 1'b1;
                    end
                end
                ALL_RED: begin
                    if (w_done) begin
                        phase_d   = GREEN;
                        active_d  = w_green_dir;
                        pending_d = (pending_q | w_pass_eff) & ~w_green_oh;
`ifdef TL_NIGHT_MODE_EN
                        from_flash_d = 1'b0;
`endif
                        w_load    = 1'b1;
                    end
                end
                default: begin
                    phase_d = GREEN;
                    w_load  = 1'b1;
                end
            endcase
        end
    end

    // State registers with synchronous reset to green on approach 0
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q      <= GREEN;
            active_q     <= '0;
            blink_idx_q  <= '0;
            pending_q    <= '0;
`ifdef TL_NIGHT_MODE_EN
            flash_on_q   <= 1'b0;
            from_flash_q <= 1'b0;
`endif
        end else begin
            phase_q      <= phase_d;
            active_q     <= active_d;
            blink_idx_q  <= blink_idx_d;
            pending_q    <= pending_d;
`ifdef TL_NIGHT_MODE_EN
            flash_on_q   <= flash_on_d;
            from_flash_q <= from_flash_d;
`endif
        end
    end

    // Lamp decode from registered state only; idle approaches hold red
    always_comb begin
        r_o = '1;
        g_o = '0;
        y_o = '0;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (active_q == TL_DIR_W'(i)) begin
                r_o[i] = 1'b0;
                case (phase_q)
                    GREEN, BLINK_ON: g_o[i] = 1'b1;
                    YELLOW:          y_o[i] = 1'b1;
                    ALL_RED:         r_o[i] = 1'b1;
                    default:         r_o[i] = 1'b0;
                endcase
            end
        end
`ifdef TL_NIGHT_MODE_EN
        if (phase_q == FLASH) begin
            r_o = '0;
            g_o = '0;
            y_o = {NUM_DIR{flash_on_q}};
        end
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_ctrl
// Description : Directed bench for traffic_light_ctrl with short durations
//               (G=8, blink 2x2, Y=4, AR=3). Two- and three-approach
//               instances plus a single-approach no-blink instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_ctrl;

    localparam int GC = 8;
    localparam int BC = 2;
    localparam int BN = 2;
    localparam int YC = 4;
    localparam int AC = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst2, rst3;
    logic [0:0] pass1, r1, g1, y1;
    logic [1:0] pass2, r2, g2, y2;
    logic [2:0] pass3, r3, g3, y3;
`ifdef TL_NIGHT_MODE_EN
    logic       night1, night2, night3;
`endif

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl #(.NUM_DIR(2), .CW(12), .G_CYC(GC), .BLINK_CYC(BC),
                         .BLINK_NUM(BN), .Y_CYC(YC), .AR_CYC(AC)) dut2 (
        .clk(clk), .rst(rst2), .pass_i(pass2),
`ifdef TL_NIGHT_MODE_EN
        .night_i(night2),
`endif
        .r_o(r2), .g_o(g2), .y_o(y2));

    traffic_light_ctrl #(.NUM_DIR(3), .CW(12), .G_CYC(GC), .BLINK_CYC(BC),
                         .BLINK_NUM(BN), .Y_CYC(YC), .AR_CYC(AC)) dut3 (
        .clk(clk), .rst(rst3), .pass_i(pass3),
`ifdef TL_NIGHT_MODE_EN
        .night_i(night3),
`endif
        .r_o(r3), .g_o(g3), .y_o(y3));

    traffic_light_ctrl #(.NUM_DIR(1), .CW(12), .G_CYC(GC), .BLINK_CYC(BC),
                         .BLINK_NUM(0), .Y_CYC(YC), .AR_CYC(AC)) dut1 (
        .clk(clk), .rst(rst1), .pass_i(pass1),
`ifdef TL_NIGHT_MODE_EN
        .night_i(night1),
`endif
        .r_o(r1), .g_o(g1), .y_o(y1));

    typedef struct packed {
        logic       rst;
        logic [1:0] pass;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] y;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [1:0] pass,
                       input logic [1:0] r, input logic [1:0] g, input logic [1:0] y);
        vec_t v;
        v.rst = rst; v.pass = pass; v.r = r; v.g = g; v.y = y;
        vecs.push_back(v);
    endtask

    // Free-running two-approach lamps for cycle c (1 = first cycle after reset)
    function automatic logic [5:0] free_run(input int c);
        if (c <= 8)                               return {2'b10, 2'b01, 2'b00};
        if ((c >= 9 && c <= 10) || (c >= 13 && c <= 14)) return {2'b10, 2'b00, 2'b00};
        if ((c >= 11 && c <= 12) || (c >= 15 && c <= 16)) return {2'b10, 2'b01, 2'b00};
        if (c <= 20)                              return {2'b10, 2'b00, 2'b01};
        if (c <= 23)                              return {2'b11, 2'b00, 2'b00};
        return {2'b01, 2'b10, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string name, input logic [2:0] r, input logic [2:0] g,
                        input logic [2:0] y);
        chk({name, ".R"}, {5'd0, r3}, {5'd0, r});
        chk({name, ".G"}, {5'd0, g3}, {5'd0, g});
        chk({name, ".Y"}, {5'd0, y3}, {5'd0, y});
    endtask

    initial begin
        logic [5:0] e;
        rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
        pass1 = '0; pass2 = '0; pass3 = '0;
`ifdef TL_NIGHT_MODE_EN
        night1 = 1'b0; night2 = 1'b0; night3 = 1'b0;
`endif

        // Free-run from reset; pass[0] during own green must be ignored
        add(1'b1, 2'b00, 2'b10, 2'b01, 2'b00);
        for (int c = 2; c <= 24; c++) begin
            e = free_run(c);
            add(1'b0, (c <= 5) ? 2'b01 : 2'b00, e[5:4], e[3:2], e[1:0]);
        end
        // pass[1] sampled in green: yellow one cycle later, then approach 1
        add(1'b1, 2'b00, 2'b10, 2'b01, 2'b00);
        add(1'b0, 2'b00, 2'b10, 2'b01, 2'b00);
        add(1'b0, 2'b00, 2'b10, 2'b01, 2'b00);
        add(1'b0, 2'b10, 2'b10, 2'b01, 2'b00);
        for (int c = 0; c < YC; c++) add(1'b0, 2'b00, 2'b10, 2'b00, 2'b01);
        for (int c = 0; c < AC; c++) add(1'b0, 2'b00, 2'b11, 2'b00, 2'b00);
        add(1'b0, 2'b00, 2'b01, 2'b10, 2'b00);
        // Truncate approach 1, request both during its yellow, then reset
        add(1'b0, 2'b01, 2'b01, 2'b10, 2'b00);
        add(1'b0, 2'b00, 2'b01, 2'b00, 2'b10);
        add(1'b0, 2'b11, 2'b01, 2'b00, 2'b10);
        add(1'b1, 2'b00, 2'b10, 2'b01, 2'b00);
        for (int c = 2; c <= 9; c++) begin
            e = free_run(c);
            add(1'b0, 2'b00, e[5:4], e[3:2], e[1:0]);
        end

        step();
        for (int i = 0; i < vecs.size(); i++) begin
            rst2  = vecs[i].rst;
            pass2 = vecs[i].pass;
            step();
            chk($sformatf("vec%0d.R", i), {6'd0, r2}, {6'd0, vecs[i].r});
            chk($sformatf("vec%0d.G", i), {6'd0, g2}, {6'd0, vecs[i].g});
            chk($sformatf("vec%0d.Y", i), {6'd0, y2}, {6'd0, vecs[i].y});
        end
        rst2 = 1'b1; pass2 = '0;

        // Three approaches: pass[2] in approach-0 yellow skips approach 1
        rst3 = 1'b1; step(); rst3 = 1'b0;
        chk3("d3_reset", 3'b110, 3'b001, 3'b000);
        repeat (16) step();
        chk3("d3_yel", 3'b110, 3'b000, 3'b001);
        pass3 = 3'b100; step(); pass3 = 3'b000;
        repeat (5) step();
        chk3("d3_allred", 3'b111, 3'b000, 3'b000);
        step();
        chk3("d3_skip1", 3'b011, 3'b100, 3'b000);

        // Simultaneous pass[1] and pass[2]: 1 served first, then 2 truncates
        rst3 = 1'b1; step(); rst3 = 1'b0;
        pass3 = 3'b110; step(); pass3 = 3'b000;
        chk3("d3_both_c2", 3'b110, 3'b001, 3'b000);
        step();
        chk3("d3_both_yel0", 3'b110, 3'b000, 3'b001);
        repeat (YC + AC) step();
        chk3("d3_green1", 3'b101, 3'b010, 3'b000);
        step();
        chk3("d3_trunc1", 3'b101, 3'b000, 3'b010);
        repeat (YC + AC) step();
        chk3("d3_green2", 3'b011, 3'b100, 3'b000);
        step();
        chk3("d3_green2_hold", 3'b011, 3'b100, 3'b000);
        rst3 = 1'b1;

        // Single approach, no blink: G 8, Y 4, AR 3, back to green
        rst1 = 1'b1; step(); rst1 = 1'b0;
        repeat (7) step();
        chk("d1_g8", {5'd0, r1, g1, y1}, 8'b010);
        step();
        chk("d1_y9", {5'd0, r1, g1, y1}, 8'b001);
        repeat (4) step();
        chk("d1_r13", {5'd0, r1, g1, y1}, 8'b100);
        repeat (2) step();
        chk("d1_r15", {5'd0, r1, g1, y1}, 8'b100);
        step();
        chk("d1_g16", {5'd0, r1, g1, y1}, 8'b010);

`ifdef TL_NIGHT_MODE_EN
        // Night flashing: Y pattern 11,11,00,00,... then all-red and approach 0
        rst2 = 1'b1; step(); rst2 = 1'b0;
        night2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("night%0d", i), {2'd0, r2, g2, y2},
                {6'd0, ((i % 4) < 2) ? 2'b11 : 2'b00});
        end
        night2 = 1'b0;
        for (int i = 0; i < AC; i++) begin
            step();
            chk($sformatf("night_ar%0d", i), {2'd0, r2, g2, y2}, 8'b00_11_00_00);
        end
        step();
        chk("night_green0", {2'd0, r2, g2, y2}, 8'b00_10_01_00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised multi-direction intersection controller, the next generation of the single-approach traffic light. It sequences NUM_DIR approaches round-robin through green, blinking green, yellow and an all-red clearance. Per-direction pedestrian/vehicle `pass` requests can truncate green and reorder service. All phase durations are parameters, and an optional night mode flashes yellow on all approaches.

## Interface
- `NUM_DIR`, 2: number of approaches; range 1..8.
- `CW`, 12: phase counter width; every duration is below 2^CW.
- `G_CYC`, 1024: steady green length in cycles.
- `BLINK_CYC`, 128: length of each blink half-period in cycles.
- `BLINK_NUM`, 2: number of off/on blink pairs after green; 0 skips the blink.
- `Y_CYC`, 512: yellow length in cycles.
- `AR_CYC`, 1024: all-red clearance length in cycles.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `pass` in NUM_DIR: request bit per direction, sampled each cycle.
- `night` in 1: night-mode request; present only with TL_NIGHT_MODE_EN.
- `R`, `G`, `Y` out NUM_DIR each: lamp drives per direction.

## Operation
- **Phases** (tl_pkg enum): GREEN, BLINK_OFF, BLINK_ON, YELLOW, ALL_RED, plus FLASH when configured.
- **Registered state:**
  - `phase`: current phase.
  - `active`: index of the served direction.
  - `cnt`: phase counter, CW bits, starts at 1.
  - `blink_idx`: blink pair index.
  - `pending`: NUM_DIR bits.
- A phase of length N occupies exactly N cycles. When `cnt == N`, the phase advances and `cnt` reloads to 1.
- **Sequence:**
  - GREEN, then BLINK_OFF/BLINK_ON repeated BLINK_NUM times, then YELLOW.
  - YELLOW, then ALL_RED, then GREEN of the next direction.
- **Lamps:**
  - Active direction: G=1 in GREEN and BLINK_ON; all lamps 0 in BLINK_OFF; Y=1 in YELLOW; R=1 in ALL_RED.
  - Every non-active direction: R=1.
  - Exactly one lamp is lit per direction, except in BLINK_OFF and FLASH.
- **Pending requests:**
  - `pass[i]` sets `pending[i]`, except when i==active and phase==GREEN, where it is ignored.
  - `pending[i]` clears on the cycle direction i enters GREEN.
- **Truncation:** in GREEN, if any `pending[j]` with j≠active is set, the next cycle enters YELLOW. Blink is skipped. `cnt` reloads to 1.
- **Next direction** at the end of ALL_RED:
  - The first pending bit scanning active+1, active+2, … mod NUM_DIR.
  - If no bit is pending, (active+1) mod NUM_DIR.
- **NUM_DIR=1:** ALL_RED returns to the same direction. With AR_CYC=1024 this reproduces the legacy single-light sequence.
- **Priority per cycle:** `rst` > `night` > truncation > timer expiry.
- Lamp outputs are combinational decodes of the registered state only, with no input-to-output path.

## Timing
- **Reset:** `rst` high at an edge sets phase=GREEN, active=0, cnt=1, pending=0, blink_idx=0. Outputs then show G[0]=1 and R[i]=1 for i≥1, with all other lamps 0.
- **Reset mid-operation:** any phase, including FLASH, returns to this state on the next cycle.
- **Request latency:** `pass` sampled at edge k during GREEN puts YELLOW on the outputs after edge k+1.
- **Simultaneous events:** a `pass` arriving on the same cycle as timer expiry is still registered. Truncation wins only in GREEN.
- **Full cycle per direction:** G_CYC + 2·BLINK_NUM·BLINK_CYC + Y_CYC + AR_CYC cycles.

## Configuration
- `TL_NIGHT_MODE_EN` defined:
  - The `night` port and FLASH phase exist.
  - `night`=1 enters FLASH on the next cycle from any phase.
  - In FLASH, R=G=0 on all directions. Y on all directions is 1 for BLINK_CYC cycles, then 0 for BLINK_CYC cycles, repeating, starting at 1.
  - Releasing `night` enters ALL_RED for AR_CYC cycles, then GREEN of direction 0.
  - `pending` is cleared on FLASH entry.
- `TL_NIGHT_MODE_EN` undefined: no `night` port and no FLASH encoding; behaviour is otherwise identical.

## Structure
- **tl_pkg:** phase enum, `TL_DIR_MAX`=8, and a round-robin next-index function.
- **tl_phase_timer:** one sub-module.
  - Loadable CW-bit counter.
  - Inputs: `load`, `limit`.
  - Output: `done` when cnt==limit.
- **Elaboration checks:** all durations ≥1 and <2^CW.

## Test plan
Parameters for scenarios 1–5: G_CYC=8, BLINK_CYC=2, BLINK_NUM=2, Y_CYC=4, AR_CYC=3, NUM_DIR=2.
1. **Reset then free-run:**
   - After reset: G=01, R=10.
   - Cycles 9–10: G=00.
   - Cycles 11–12: G=01.
   - YELLOW on cycles 17–20: Y=01.
   - R=11 on cycles 21–23.
   - Cycle 24: G=10, R=01.
2. **`pass[1]` pulse at GREEN cycle 3** → YELLOW from cycle 4 for 4 cycles, ALL_RED for 3 cycles, then G=10.
3. **NUM_DIR=3, `pass[2]` during direction-0 YELLOW** → direction 2 green after ALL_RED; direction 1 is skipped.
4. **NUM_DIR=3, `pass[1]` and `pass[2]` in the same cycle during direction-0 GREEN** → direction 1 is served first (green truncated at once), then direction 2 truncates direction-1 green.
5. **`rst` asserted during YELLOW of direction 1** → next cycle G=01, R=10, pending=0.
6. **With TL_NIGHT_MODE_EN, `night` high for 10 cycles** → Y=11,11,00,00,… with R=G=0. After release: R=11 for 3 cycles, then G=01.
